// File: rtl/audio_pkg.sv
// Shared constants and types for the audio DAC path.
// Sample/slot widths and the default bit-clock divider.
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 24;
  localparam int AUDIO_SLOT_W   = 32;
  localparam int AUDIO_CLK_DIV  = 8;

  typedef logic [AUDIO_SAMPLE_W-1:0] audio_sample_t;

endpackage

// File: rtl/audio_bclk_div.sv
// Codec bit-clock divider: toggles aud_bclk every CLK_DIV clk
// and flags the clk cycle on which each BCLK edge is registered.
module audio_bclk_div
  import audio_pkg::*;
#(
  parameter int CLK_DIV = AUDIO_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic aud_bclk,
  output logic fall_evt,
  output logic rise_evt
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap     = (div_cnt == DIV_LAST);
  assign fall_evt = wrap & aud_bclk;
  assign rise_evt = wrap & ~aud_bclk;

  // Half-period counter; BCLK flips on each wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      aud_bclk <= 1'b0;
    end else if (wrap) begin
      div_cnt  <= '0;
      aud_bclk <= ~aud_bclk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// Mono sample buffer + I2S serialiser driving both codec slots.
// Define AUDIO_DAC_LJ_EN for left-justified slots instead of I2S.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int CLK_DIV  = AUDIO_CLK_DIV,
  parameter int SAMPLE_W = AUDIO_SAMPLE_W,
  parameter int SLOT_W   = AUDIO_SLOT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                mute,
  output logic                aud_bclk,
  output logic                aud_daclrck,
  output logic                aud_dacdat,
  output logic                underrun
);

  localparam int BW = $clog2(2 * SLOT_W);
  localparam int PW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] SLOT_B    = BW'(SLOT_W);
  localparam logic [PW-1:0] SLOT_LAST = PW'(SLOT_W - 1);

  logic                fall_evt;
  logic                rise_evt;
  logic [BW-1:0]       bit_cnt;
  logic [BW-1:0]       bit_nxt;
  logic [PW-1:0]       pos;
  logic                lr_nxt;
  logic                frame_start;
  logic                accept;
  logic                buf_full;
  logic [SAMPLE_W-1:0] buf_data;
  logic [SAMPLE_W-1:0] frame_reg;
  logic [SAMPLE_W-1:0] frame_nxt;
  logic [SLOT_W-1:0]   slot_vec;
  logic                dat_nxt;

  audio_bclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .aud_bclk (aud_bclk),
    .fall_evt (fall_evt),
    .rise_evt (rise_evt)
  );

  assign sample_ready = ~buf_full;
  assign accept       = sample_valid & ~buf_full;

  // Slot bits laid out MSB-first: slot position p reads bit SLOT_W-1-p.
`ifdef AUDIO_DAC_LJ_EN
  assign slot_vec = SLOT_W'({frame_nxt, SLOT_W'(0)} >> SAMPLE_W);
`else
  assign slot_vec = SLOT_W'({1'b0, frame_nxt, SLOT_W'(0)} >> (SAMPLE_W + 1));
`endif

  // Next bit position, slot side and the word that frame will carry.
  always_comb begin
    bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    frame_start = fall_evt & (bit_nxt == '0);
    lr_nxt      = (bit_nxt >= SLOT_B);
    pos         = lr_nxt ? PW'(bit_nxt - SLOT_B) : PW'(bit_nxt);
    frame_nxt   = frame_reg;
    if (frame_start) begin
      if (mute)
        frame_nxt = '0;
      else if (buf_full)
        frame_nxt = buf_data;
    end
    dat_nxt = slot_vec[SLOT_LAST - pos];
  end

  // One-entry holding buffer; drained only at a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_data <= sample;
    end else if (frame_start) begin
      buf_full <= 1'b0;
    end
  end

  // Bit position, frame word and pins move on each BCLK fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= BIT_LAST;
      frame_reg   <= '0;
      aud_daclrck <= 1'b0;
      aud_dacdat  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      underrun <= frame_start & ~buf_full;
      if (fall_evt) begin
        bit_cnt     <= bit_nxt;
        frame_reg   <= frame_nxt;
        aud_daclrck <= lr_nxt;
        aud_dacdat  <= dat_nxt;
      end
    end
  end

  // The divider never flags both BCLK edges in one cycle.
  a_one_edge: assert property (
    @(posedge clk) disable iff (rst) !(fall_evt && rise_evt)
  );

endmodule
